// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the Booth multiplier and its sequencer.
//   state_t        - sequencer FSM encoding (IDLE=0, CLR=1, LOAD=2, WAIT=3)
//   BOOTH_W        - default operand width of the multiplier
//   BOOTH_TIMEOUT  - default WAIT-state cycle budget before an error result
//   neg_limit(w)   - most negative w-bit two's-complement value, -2^(w-1)
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    LOAD = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam int BOOTH_W       = 4;
  localparam int BOOTH_TIMEOUT = 15;

  function automatic int neg_limit(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if: operand and result streams of the Booth sequencer.
//   op_valid/op_ready/op_a/op_b      - signed operand pair, valid/ready
//   res_valid/res_ready/res_p/res_err - held product or error, valid/ready
// Modports:
//   slave  - the sequencer (consumes operands, produces results)
//   master - the environment (produces operands, consumes results)
interface booth_seq_ctrl_if #(
  parameter int W = 4
);
  logic                    op_valid;
  logic                    op_ready;
  logic signed [W-1:0]     op_a;
  logic signed [W-1:0]     op_b;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [2*W-1:0]   res_p;
  logic                    res_err;

  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_p, res_err
  );

  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_p, res_err
  );
endinterface

// File: rtl/booths.sv
// booths: sequential radix-2 Booth multiplier, one partial step per cycle.
// Ports:
//   clk, reset - clock and synchronous active-high reset (clears ready)
//   start      - load b and begin W shift steps
//   a, b       - signed multiplicand / multiplier; a must stay stable
//   p          - signed 2W-bit product {acc, q}
//   ready      - sticky done flag, cleared only by reset (or a new start)
// The accumulator is W bits wide, so a = -2^(W-1) is not supported: its
// negation does not fit. The upstream sequencer rejects that operand.
module booths
  import booth_pkg::*;
#(
  parameter int W = BOOTH_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p,
  output logic                  ready
);
  localparam int NW = $clog2(W + 1);

  logic signed [W-1:0] m;
  logic signed [W-1:0] neg_m;
  logic signed [W-1:0] acc;
  logic        [W-1:0] q;
  logic                q_1;
  logic [NW-1:0]       cnt;
  logic                busy;
  logic signed [W-1:0] sum;

  // Booth recoding of the current multiplier bit pair {q[0], q_1}.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc + neg_m;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m     <= '0;
      neg_m <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      // A and its negation are sampled every cycle, hence the stable-A rule.
      m     <= a;
      neg_m <= -a;
      if (start) begin
        acc   <= '0;
        q     <= b;
        q_1   <= 1'b0;
        cnt   <= NW'(W);
        busy  <= 1'b1;
        ready <= 1'b0;
      end else if (busy) begin
        if (cnt != '0) begin
          // Arithmetic shift right of {sum, q, q_1}.
          acc <= {sum[W-1], sum[W-1:1]};
          q   <= {sum[0], q[W-1:1]};
          q_1 <= q[0];
          cnt <= cnt - NW'(1);
        end else begin
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      end
    end
  end

  assign p = {acc, q};

endmodule

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequences one operand pair at a time through the booths
// multiplier and holds the product until downstream accepts it.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   io (slave)           - operand stream in, result stream out
//   mul_reset            - multiplier reset: reset OR state==CLR
//   mul_start            - multiplier start, high for the single LOAD cycle
//   mul_a, mul_b         - registered operands, held from accept to capture
//   mul_p, mul_ready     - multiplier product and sticky done flag
// An operand a = -2^(W-1) is rejected in IDLE with an error result; a
// multiplier that never signals ready yields an error after TIMEOUT cycles.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int W       = BOOTH_W,
  parameter  int TIMEOUT = BOOTH_TIMEOUT,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  booth_seq_ctrl_if.slave       io,
  output logic                  mul_reset,
  output logic                  mul_start,
  output logic signed [W-1:0]   mul_a,
  output logic signed [W-1:0]   mul_b,
  input  logic signed [2*W-1:0] mul_p,
  input  logic                  mul_ready
);
  localparam logic signed [W-1:0] NEG_LIM = W'(neg_limit(W));

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          reject;
  logic          capture;
  logic          timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    io.op_ready = 1'b0;
    mul_reset   = reset;
    mul_start   = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        // Uses the registered res_valid only: a result released this cycle
        // lets the next pair in, but there is no same-cycle pass-through.
        io.op_ready = !io.res_valid;
        if (io.op_valid && !io.res_valid) begin
          if (io.op_a == NEG_LIM) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = CLR;
          end
        end
      end
      CLR: begin
        // Clears the multiplier's sticky ready left over from the last op.
        mul_reset  = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        mul_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // A ready arriving on the last budget cycle still wins.
        if (mul_ready) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a        <= '0;
      mul_b        <= '0;
      cnt          <= '0;
      io.res_valid <= 1'b0;
      io.res_p     <= '0;
      io.res_err   <= 1'b0;
    end else begin
      if (accept) begin
        mul_a <= io.op_a;
        mul_b <= io.op_b;
      end

      if (state == LOAD)      cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);

      if (reject || timeout_hit) begin
        io.res_valid <= 1'b1;
        io.res_err   <= 1'b1;
        io.res_p     <= '0;
      end else if (capture) begin
        io.res_valid <= 1'b1;
        io.res_err   <= 1'b0;
        io.res_p     <= mul_p;
      end else if (io.res_valid && io.res_ready) begin
        io.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed bench for booth_seq_ctrl driving the booths
// multiplier. A stub mode forces the multiplier's ready low.
module tb_booth_seq_ctrl;
  import booth_pkg::*;

  localparam int W = 4;

  logic                  clk;
  logic                  reset;
  logic                  mul_reset;
  logic                  mul_start;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [2*W-1:0] mul_p;
  logic                  b_ready;
  logic                  stub_mode;
  logic                  dut_mul_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  booth_seq_ctrl_if #(.W(W)) io ();

  assign dut_mul_ready = stub_mode ? 1'b0 : b_ready;

  booth_seq_ctrl #(.W(W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (io),
    .mul_reset (mul_reset),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .mul_ready (dut_mul_ready)
  );

  booths #(.W(W)) mult (
    .clk   (clk),
    .reset (mul_reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p),
    .ready (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a pair from a negedge until the next edge accepts it; returns at
  // the negedge right after the accepting edge.
  task automatic do_accept(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!io.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (io.op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: op_ready=%b required 1 within 50 cycles", io.op_ready);
    end
    io.op_valid = 1'b1;
    io.op_a     = a;
    io.op_b     = b;
    @(negedge clk);
    io.op_valid = 1'b0;
  endtask

  // Waits for res_valid; lat counts edges from the accepting edge.
  task automatic wait_result(output int lat, output int starts, output int resets,
                             output bit order_ok);
    bit prev_rst = 1'b0;
    lat = 1; starts = 0; resets = 0; order_ok = 1'b0;
    while (!io.res_valid && lat < 40) begin
      if (mul_start) begin
        starts++;
        if (prev_rst) order_ok = 1'b1;
      end
      if (mul_reset) resets++;
      prev_rst = mul_reset;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mul_reset !== 1'b1) begin
      n_fail++; $display("FAIL reset_mul_reset: got %b required 1", mul_reset);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({io.op_ready, io.res_valid, io.res_err, mul_start, mul_reset} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {op_ready,res_valid,res_err,mul_start,mul_reset}=%b required 10000",
               {io.op_ready, io.res_valid, io.res_err, mul_start, mul_reset});
    end
    n_cmp++;
    if (io.res_p !== 8'h00 || mul_a !== 4'h0 || mul_b !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data: res_p=%h mul_a=%h mul_b=%h required 00 0 0", io.res_p, mul_a, mul_b);
    end
  endtask

  task automatic test_basic();
    int lat, starts, resets; bit order_ok;
    io.res_ready = 1'b1;
    do_accept(4'sd3, 4'sd2);
    n_cmp++;
    if (mul_a !== 4'h3 || mul_b !== 4'h2) begin
      n_fail++; $display("FAIL basic_latch: mul_a=%h mul_b=%h required 3 2", mul_a, mul_b);
    end
    wait_result(lat, starts, resets, order_ok);
    n_cmp++;
    if (io.res_p !== 8'h06 || io.res_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_product: res_p=%h err=%b required 06 0", io.res_p, io.res_err);
    end
    n_cmp++;
    if (lat < 6 || lat > 9) begin
      n_fail++; $display("FAIL basic_latency: got %0d required 6..9", lat);
    end
    n_cmp++;
    if (starts != 1 || resets != 1 || !order_ok) begin
      n_fail++;
      $display("FAIL basic_pulses: starts=%0d resets=%0d reset_before_start=%b required 1 1 1",
               starts, resets, order_ok);
    end
    @(negedge clk);
    n_cmp++;
    if (io.res_valid !== 1'b0 || io.op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: res_valid=%b op_ready=%b required 0 1", io.res_valid, io.op_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0]   av [4] = '{-4'sd3, -4'sd7, -4'sd7, 4'sd5};
    logic signed [W-1:0]   bv [4] = '{4'sd2, -4'sd7, 4'sd7, -4'sd1};
    logic        [2*W-1:0] pv [4] = '{8'hFA, 8'h31, 8'hCF, 8'hFB};
    int lat, starts, resets; bit order_ok;
    io.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_accept(av[i], bv[i]);
      wait_result(lat, starts, resets, order_ok);
      n_cmp++;
      if (io.res_p !== pv[i] || io.res_err !== 1'b0 || lat < 6 || lat > 9) begin
        n_fail++;
        $display("FAIL b2b_%0d: res_p=%h err=%b lat=%0d required %h 0 6..9",
                 i, io.res_p, io.res_err, lat, pv[i]);
      end
    end
  endtask

  task automatic test_reject();
    int starts = 0;
    io.res_ready = 1'b1;
    do_accept(4'sh8, 4'sd3);
    n_cmp++;
    if (io.res_valid !== 1'b1 || io.res_err !== 1'b1 || io.res_p !== 8'h00) begin
      n_fail++;
      $display("FAIL reject_result: valid=%b err=%b p=%h required 1 1 00",
               io.res_valid, io.res_err, io.res_p);
    end
    n_cmp++;
    if (io.op_ready !== 1'b0 || mul_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_idle: op_ready=%b mul_reset=%b required 0 0", io.op_ready, mul_reset);
    end
    for (int i = 0; i < 4; i++) begin
      if (mul_start) starts++;
      @(negedge clk);
    end
    n_cmp++;
    if (starts != 0 || io.op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_no_start: starts=%0d op_ready=%b required 0 1", starts, io.op_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat, starts, resets; bit order_ok; bit held = 1'b1;
    io.res_ready = 1'b0;
    do_accept(4'sd2, 4'sd3);
    wait_result(lat, starts, resets, order_ok);
    for (int i = 0; i < 10; i++) begin
      if (io.res_valid !== 1'b1 || io.res_p !== 8'h06 || io.op_ready !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: last valid=%b p=%h op_ready=%b required 1 06 0",
               io.res_valid, io.res_p, io.op_ready);
    end
    io.res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (io.res_valid !== 1'b0 || io.op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: res_valid=%b op_ready=%b required 0 1", io.res_valid, io.op_ready);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int guard = 0;
    stub_mode    = 1'b1;
    io.res_ready = 1'b0;
    do_accept(4'sd2, 4'sd2);
    while (!mul_start && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    while (!io.res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n - 1 != 15) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d in WAIT required 15", n - 1);
    end
    n_cmp++;
    if (io.res_err !== 1'b1 || io.res_p !== 8'h00) begin
      n_fail++; $display("FAIL timeout_result: err=%b p=%h required 1 00", io.res_err, io.res_p);
    end
    io.res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (io.op_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_idle: op_ready=%b required 1", io.op_ready);
    end
    stub_mode = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int lat, starts, resets; bit order_ok;
    int guard = 0;
    io.res_ready = 1'b1;
    do_accept(4'sd3, 4'sd3);
    while (!mul_start && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mul_reset !== 1'b1) begin
      n_fail++; $display("FAIL midwait_mul_reset: got %b required 1", mul_reset);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (io.res_valid !== 1'b0 || io.op_ready !== 1'b1 || mul_a !== 4'h0) begin
      n_fail++;
      $display("FAIL midwait_idle: res_valid=%b op_ready=%b mul_a=%h required 0 1 0",
               io.res_valid, io.op_ready, mul_a);
    end
    do_accept(4'sd1, 4'sd1);
    wait_result(lat, starts, resets, order_ok);
    n_cmp++;
    if (io.res_p !== 8'h01 || io.res_err !== 1'b0) begin
      n_fail++; $display("FAIL midwait_next: res_p=%h err=%b required 01 0", io.res_p, io.res_err);
    end
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    stub_mode    = 1'b0;
    io.op_valid  = 1'b0;
    io.op_a      = '0;
    io.op_b      = '0;
    io.res_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reject();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
